// File: rtl/dpram_fifo_if.sv
// Valid/ready handshake bundle for dpram_fifo: producer-side push port,
// consumer-side pop port and the occupancy count.
interface dpram_fifo_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic [ADDR_WIDTH+1:0] count;

  // Environment side: drives pushes and pop acknowledges.
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  count
  );

  // FIFO side.
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output count
  );

endinterface

// File: rtl/dpram_fifo.sv
// First-word-fall-through FIFO over a single dual-port RAM block, with a
// 2-entry output buffer that hides the registered RAM read latency.

// Simple dual-port RAM: port A writes, port B reads with one cycle latency.
module dpram_block #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clka,
  input  logic                  we_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] datain_a,
  input  logic                  clkb,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  output logic [DATA_WIDTH-1:0] dataout_b
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  // NOTE: RAM arrays get no reset; clearing them would prevent block-RAM
  // inference, and the FIFO pointers alone decide which words are valid.
  always_ff @(posedge clka) begin
    if (we_a) mem[addr_a] <= datain_a;
  end

  always_ff @(posedge clkb) begin
    dataout_b <= mem[addr_b];
  end

endmodule

module dpram_fifo #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  dpram_fifo_if.slave  bus
);

  if (!(DATA_WIDTH == 4 || DATA_WIDTH == 8 || DATA_WIDTH == 16)) begin : g_bad_width
    $error("dpram_fifo: DATA_WIDTH must be 4, 8 or 16");
  end
  if ((2**ADDR_WIDTH) * DATA_WIDTH > 16384) begin : g_bad_depth
    $error("dpram_fifo: ADDR_WIDTH too large for one 2KB RAM block");
  end

  typedef logic [ADDR_WIDTH:0]   ptr_t;
  typedef logic [ADDR_WIDTH+1:0] cnt_t;
  typedef logic [DATA_WIDTH-1:0] word_t;

  localparam ptr_t PTR_ONE  = ptr_t'(1);
  localparam ptr_t RAM_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

  ptr_t       wr_ptr;
  ptr_t       rd_ptr;
  ptr_t       ram_cnt;
  logic       inflight;
  logic [1:0] ob_cnt;
  logic [1:0] ob_load;
  word_t      ob0;
  word_t      ob1;
  word_t      dataout_b;

  logic push;
  logic pop;
  logic issue;
  logic capture;

  // Extra pointer MSB separates a full RAM from an empty one.
  assign ram_cnt = wr_ptr - rd_ptr;

  assign bus.in_ready  = (ram_cnt != RAM_FULL);
  assign bus.out_valid = (ob_cnt != 2'd0);
  assign bus.out_data  = ob0;
  assign bus.count     = cnt_t'(ram_cnt) + cnt_t'(ob_cnt) + cnt_t'(inflight);

  assign push    = bus.in_valid & bus.in_ready;
  assign pop     = bus.out_valid & bus.out_ready;
  assign capture = inflight;

  // A read may only start if its word is guaranteed a slot in the output
  // buffer when it lands; a pop this cycle frees exactly one slot.
  assign ob_load = ob_cnt + {1'b0, inflight};
  assign issue   = (ram_cnt != '0) & ((ob_load < 2'd2) | pop);

  dpram_block #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clka      (clk),
    .we_a      (push & ~flush),
    .addr_a    (wr_ptr[ADDR_WIDTH-1:0]),
    .datain_a  (bus.in_data),
    .clkb      (clk),
    .addr_b    (rd_ptr[ADDR_WIDTH-1:0]),
    .dataout_b (dataout_b)
  );

  // NOTE: every register below is updated with <= so that all of them see
  // the pre-edge values of push/pop/issue, whatever the statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else if (flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      inflight <= 1'b0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + PTR_ONE;
      if (issue) rd_ptr <= rd_ptr + PTR_ONE;
      inflight <= issue;
    end
  end

  // ob0 is always the head; ob1 is only meaningful when ob_cnt == 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else if (flush) begin
      ob_cnt <= 2'd0;
      ob0    <= '0;
      ob1    <= '0;
    end else begin
      unique case ({capture, pop})
        2'b10: begin
          if (ob_cnt == 2'd0) ob0 <= dataout_b;
          else                ob1 <= dataout_b;
          ob_cnt <= ob_cnt + 2'd1;
        end
        2'b01: begin
          ob0    <= ob1;
          ob_cnt <= ob_cnt - 2'd1;
        end
        2'b11: begin
          if (ob_cnt == 2'd1) begin
            ob0 <= dataout_b;
          end else begin
            ob0 <= ob1;
            ob1 <= dataout_b;
          end
        end
        default: ;
      endcase
    end
  end

  // The issue rule must never let a landing word find the buffer full.
  assert property (@(posedge clk) disable iff (reset)
    !(capture && !pop && ob_cnt == 2'd2));

  assert property (@(posedge clk) disable iff (reset)
    bus.count <= cnt_t'(2**ADDR_WIDTH + 2));

endmodule

// File: tb/tb_dpram_fifo.sv
// Randomised scoreboard bench for dpram_fifo (ADDR_WIDTH=4, DATA_WIDTH=16):
// the reference model is a plain queue of the words the FIFO should hold.
module tb_dpram_fifo;

  localparam int AW  = 4;
  localparam int DW  = 16;
  localparam int CAP = 2**AW + 2;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  dpram_fifo_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dpram_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle of stimulus. Inputs are applied just after an edge,
  // the handshake is sampled at the negedge, and the model follows the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic r,
                      input logic f, output logic acc);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    flush         = f;
    @(negedge clk);
    acc = v && bus.in_ready && !f;
    @(posedge clk);
    if (f)        exp_q.delete();
    else if (acc) exp_q.push_back(d);
    #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    flush         = 1'b0;
  endtask

  task automatic drain(input string name, input bit random_ready);
    logic acc;
    int   k = 0;
    while ((exp_q.size() != 0 || bus.count != 0) && k < 400) begin
      step(1'b0, '0, random_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, acc);
      k++;
    end
    check(name, 32'(bus.count), 32'd0);
  endtask

  // Monitor: compares occupancy and every popped word against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        check("count", 32'(bus.count), 32'(exp_q.size()));
        check("count_le_cap", 32'(bus.count <= CAP), 32'd1);
        if (bus.out_valid && bus.out_ready && !flush) begin
          check("pop_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic          seen;
    logic [DW-1:0] wd;
    int            n_acc;

    reset = 1'b1;
    flush = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_count",     32'(bus.count),     32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_data",  32'(bus.out_data),  32'd0);

    // Latency: one word, consumer not ready.
    step(1'b1, 16'hA5A5, 1'b0, 1'b0, acc);
    check("lat_accept",   32'(acc),           32'd1);
    check("lat_c1_count", 32'(bus.count),     32'd1);
    check("lat_c1_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("lat_c2_valid", 32'(bus.out_valid), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("lat_c3_valid", 32'(bus.out_valid), 32'd1);
    check("lat_c3_data",  32'(bus.out_data),  32'hA5A5);
    drain("lat_drain", 1'b0);

    // Streaming: push and pop every cycle.
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0, acc);
      check("stream_accept", 32'(acc), 32'd1);
      if (seen) check("stream_bubble", 32'(bus.out_valid), 32'd1);
      else      seen = bus.out_valid;
      if (i == 50) check("stream_count", 32'(bus.count), 32'd3);
    end
    drain("stream_drain", 1'b0);

    // Fill: consumer stalled, producer offers 20 words.
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 16'h1000 + 16'(n_acc), 1'b0, 1'b0, acc);
      if (acc) n_acc++;
    end
    check("fill_accepted", 32'(n_acc),         32'(CAP));
    check("fill_in_ready", 32'(bus.in_ready),  32'd0);
    check("fill_count",    32'(bus.count),     32'(CAP));
    step(1'b0, '0, 1'b1, 1'b0, acc);
    for (int k = 0; k < 1 && !bus.in_ready; k++) step(1'b0, '0, 1'b0, 1'b0, acc);
    check("fill_reready", 32'(bus.in_ready), 32'd1);
    drain("fill_drain", 1'b0);

    // Wrap: random valid/ready gaps over several fill/drain rounds.
    for (int rnd = 0; rnd < 5; rnd++) begin
      int sent  = 0;
      int guard = 0;
      wd = 16'($urandom);
      while (sent < 16 && guard < 500) begin
        step(1'($urandom_range(0, 2) != 0), wd, 1'($urandom_range(0, 3) == 0), 1'b0, acc);
        if (acc) begin
          sent++;
          wd = 16'($urandom);
        end
        guard++;
      end
      check("wrap_sent", 32'(sent), 32'd16);
      drain("wrap_drain", 1'b1);
    end

    // Asynchronous reset between edges in the middle of a stream.
    for (int i = 0; i < 20; i++) step(1'b1, 16'h2000 + 16'(i), 1'b1, 1'b0, acc);
    bus.in_valid  = 1'b1;
    bus.in_data   = 16'h2014;
    bus.out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'd0);
    check("arst_count",     32'(bus.count),     32'd0);
    check("arst_out_data",  32'(bus.out_data),  32'd0);
    exp_q.delete();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    check("arst_in_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 10; i++) step(1'b1, 16'h3000 + 16'(i), 1'b1, 1'b0, acc);
    drain("arst_drain", 1'b0);

    // Flush with 10 held words and a push and pop in the flush cycle.
    for (int i = 0; i < 10; i++) step(1'b1, 16'h4000 + 16'(i), 1'b0, 1'b0, acc);
    step(1'b0, '0, 1'b0, 1'b0, acc);
    check("flush_pre_count", 32'(bus.count), 32'd10);
    step(1'b1, 16'hDEAD, 1'b1, 1'b1, acc);
    check("flush_count",     32'(bus.count),     32'd0);
    check("flush_out_valid", 32'(bus.out_valid), 32'd0);
    check("flush_in_ready",  32'(bus.in_ready),  32'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, acc);
      check("flush_no_stale", 32'(bus.out_valid), 32'd0);
    end
    step(1'b1, 16'h4242, 1'b0, 1'b0, acc);
    drain("flush_drain", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
